serial_word_receiver: RTL and testbench

Serial-to-parallel receiving end for the 4-bit shift-register serializer: it samples the serializer's S_OUT stream on its own S_IN, assembles WIDTH-bit words in MSB-first or LSB-first order, and presents each completed word on Q with a valid/ready handshake. It sits downstream of the register block on the same CLK and ENB and turns its serial output back into parallel data for a consumer.

---
 rtl/serial_word_receiver_if.sv | 32 +++
 rtl/serial_word_receiver.sv | 151 +++++++++++++++
 tb/tb_serial_word_receiver.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_receiver_if
// Purpose  : Serial input, consumer handshake and status bundle for
//            serial_word_receiver.
// Revision : 1.0  initial release
// ============================================================================
interface serial_word_receiver_if #(
    parameter int WIDTH = 4
);
    logic             ENB;
    logic             START;
    logic             DIR;
    logic             S_IN;
    logic             RDY;
    logic [WIDTH-1:0] Q;
    logic             VALID;
    logic             BUSY;
    logic             OVERRUN;
    logic             PAR_ERR;

    modport master (
        output ENB, START, DIR, S_IN, RDY,
        input  Q, VALID, BUSY, OVERRUN, PAR_ERR
    );

    modport slave (
        input  ENB, START, DIR, S_IN, RDY,
        output Q, VALID, BUSY, OVERRUN, PAR_ERR
    );
endinterface
`default_nettype wire

// File: rtl/serial_word_receiver.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_receiver
// Purpose  : Assembles WIDTH-bit words from an ENB-qualified serial stream
//            (MSB- or LSB-first) and offers them on a valid/ready handshake.
//            Optional macro SERIAL_PARITY_EN adds an even-parity bit per frame.
// Revision : 1.0  initial release
// ============================================================================
module serial_word_receiver #(
    parameter int WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 RESET_L,
    serial_word_receiver_if.slave bus
);

`ifdef SERIAL_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_LEN = WIDTH + PAR_BITS;
    localparam int CNT_W     = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   buf_q,   buf_d;
    logic               dir_q,   dir_d;
    logic [WIDTH-1:0]   q_q,     q_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic [WIDTH-1:0]   buf_shift;
    logic               last_bit;
`ifdef SERIAL_PARITY_EN
    logic               par_err_q, par_err_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        dir_d     = dir_q;
        q_d       = q_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
`ifdef SERIAL_PARITY_EN
        par_err_d = par_err_q;
`endif
        buf_shift = dir_q ? {buf_q[WIDTH-2:0], bus.S_IN}
                          : {bus.S_IN, buf_q[WIDTH-1:1]};
        last_bit  = (cnt_q == CNT_W'(FRAME_LEN - 1));

        case (state_q)
            IDLE: begin
                if (bus.ENB && bus.START) begin
                    dir_d   = bus.DIR;
                    cnt_d   = '0;
                    buf_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.ENB) begin
                    if (bus.START) begin
                        dir_d = bus.DIR;
                        cnt_d = '0;
                        buf_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
`ifdef SERIAL_PARITY_EN
                        // The trailing slot is the parity bit; the buffer already holds all data.
                        if (last_bit) begin
                            q_d       = buf_q;
                            valid_d   = 1'b1;
                            par_err_d = (^buf_q) ^ bus.S_IN;
                            state_d   = HOLD;
                        end else begin
                            buf_d = buf_shift;
                        end
`else
                        buf_d = buf_shift;
                        if (last_bit) begin
                            q_d     = buf_shift;
                            valid_d = 1'b1;
                            state_d = HOLD;
                        end
`endif
                    end
                end
            end
            HOLD: begin
                if (bus.ENB && bus.START) begin
                    overrun_d = 1'b1;
                end
                if (valid_q && bus.RDY) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            buf_q     <= '0;
            dir_q     <= 1'b0;
            q_q       <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            dir_q     <= dir_d;
            q_q       <= q_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef SERIAL_PARITY_EN
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
    assign bus.PAR_ERR = par_err_q;
`else
    assign bus.PAR_ERR = 1'b0;
`endif

    assign bus.Q       = q_q;
    assign bus.VALID   = valid_q;
    assign bus.BUSY    = (state_q == SHIFT);
    assign bus.OVERRUN = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_receiver.sv
`default_nettype none
// Testbench for serial_word_receiver: directed scenarios plus randomized frames
// checked against a bit-position model of the frame format.
module tb_serial_word_receiver;
    localparam int WIDTH = 4;
`ifdef SERIAL_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic CLK = 1'b0;
    logic RESET_L;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    serial_word_receiver_if #(.WIDTH(WIDTH)) bus ();

    serial_word_receiver #(.WIDTH(WIDTH)) dut (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // The i-th transmitted bit is tx[WIDTH-1-i]; it lands at the far end chosen by dir.
    function automatic logic [WIDTH-1:0] model_word(input logic dir, input logic [WIDTH-1:0] tx);
        logic [WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (dir) w[WIDTH-1-i] = tx[WIDTH-1-i];
            else     w[i]         = tx[WIDTH-1-i];
        end
        return w;
    endfunction

    function automatic logic model_par(input logic [WIDTH-1:0] tx, input logic pbit);
        int ones;
        ones = 0;
        for (int i = 0; i < WIDTH; i++) ones += int'(tx[i]);
        ones += int'(pbit);
        return (PBITS == 1) ? logic'(ones % 2) : 1'b0;
    endfunction

    task automatic drive_frame(input logic dir, input logic [WIDTH-1:0] tx, input logic pbit,
                               input int max_gap, input int gap_idx, input int gap_len,
                               output int busy_bad, output int valid_early);
        busy_bad    = 0;
        valid_early = 0;
        bus.ENB   = 1'b1;
        bus.START = 1'b1;
        bus.DIR   = dir;
        tick();
        bus.START = 1'b0;
        for (int i = 0; i < WIDTH + PBITS; i++) begin
            int g;
            g = (i == gap_idx) ? gap_len : ((max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
            for (int k = 0; k < g; k++) begin
                bus.ENB  = 1'b0;
                bus.S_IN = 1'($urandom);
                bus.DIR  = 1'($urandom);
                tick();
                if (bus.BUSY !== 1'b1) busy_bad++;
                if (bus.VALID !== 1'b0) valid_early++;
            end
            bus.ENB  = 1'b1;
            bus.S_IN = (i < WIDTH) ? tx[WIDTH-1-i] : pbit;
            bus.DIR  = 1'($urandom);
            if (bus.BUSY !== 1'b1) busy_bad++;
            if (bus.VALID !== 1'b0) valid_early++;
            tick();
        end
    endtask

    task automatic accept();
        bus.RDY = 1'b1;
        tick();
        bus.RDY = 1'b0;
    endtask

    task automatic do_reset();
        RESET_L = 1'b0;
        #2;
        RESET_L = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        int bb, ve;
        logic [WIDTH-1:0] exp_q;
        RESET_L = 1'b0;
        repeat (2) tick();
        checks++;
        if ({bus.Q, bus.VALID, bus.BUSY, bus.OVERRUN, bus.PAR_ERR} !== '0) begin
            failures++;
            $display("FAIL reset_values: got %0h expected 0", {bus.Q, bus.VALID, bus.BUSY, bus.OVERRUN, bus.PAR_ERR});
        end
        RESET_L = 1'b1;
        tick();
        drive_frame(1'b1, 4'b1011, 1'b0, 0, -1, 0, bb, ve);
        checks++;
        if (bus.VALID !== 1'b1) begin
            failures++;
            $display("FAIL hold_before_reset: VALID got %b expected 1", bus.VALID);
        end
        #2 RESET_L = 1'b0;
        #1;
        checks++;
        if ({bus.Q, bus.VALID, bus.BUSY, bus.OVERRUN, bus.PAR_ERR} !== '0) begin
            failures++;
            $display("FAIL reset_in_hold: got %0h expected 0", {bus.Q, bus.VALID, bus.BUSY, bus.OVERRUN, bus.PAR_ERR});
        end
        RESET_L = 1'b1;
        tick();
        bus.ENB = 1'b1; bus.START = 1'b1; bus.DIR = 1'b1;
        tick();
        bus.START = 1'b0; bus.S_IN = 1'b1;
        tick();
        bus.S_IN = 1'b0;
        tick();
        checks++;
        if (bus.BUSY !== 1'b1) begin
            failures++;
            $display("FAIL busy_mid_frame: got %b expected 1", bus.BUSY);
        end
        #2 RESET_L = 1'b0;
        #1;
        checks++;
        if ({bus.Q, bus.VALID, bus.BUSY, bus.OVERRUN, bus.PAR_ERR} !== '0) begin
            failures++;
            $display("FAIL reset_in_shift: got %0h expected 0", {bus.Q, bus.VALID, bus.BUSY, bus.OVERRUN, bus.PAR_ERR});
        end
        RESET_L = 1'b1;
        tick();
        drive_frame(1'b1, 4'b0011, 1'b0, 0, -1, 0, bb, ve);
        exp_q = model_word(1'b1, 4'b0011);
        checks++;
        if (bus.Q !== exp_q || bus.VALID !== 1'b1) begin
            failures++;
            $display("FAIL frame_after_reset: Q=%b VALID=%b expected Q=%b VALID=1", bus.Q, bus.VALID, exp_q);
        end
        accept();
    endtask

    task automatic test_msb_frame();
        int bb, ve;
        logic [WIDTH-1:0] exp_q;
        for (int p = 1; p >= 0; p--) begin
            drive_frame(1'b1, 4'b1011, 1'(p), 0, -1, 0, bb, ve);
            exp_q = model_word(1'b1, 4'b1011);
            checks++;
            if (bus.Q !== exp_q || bus.VALID !== 1'b1 || bus.BUSY !== 1'b0 || ve != 0 || bb != 0) begin
                failures++;
                $display("FAIL msb_frame: Q=%b VALID=%b BUSY=%b early=%0d busybad=%0d expected Q=%b VALID=1 BUSY=0",
                         bus.Q, bus.VALID, bus.BUSY, ve, bb, exp_q);
            end
            checks++;
            if (bus.PAR_ERR !== model_par(4'b1011, 1'(p))) begin
                failures++;
                $display("FAIL msb_par_err: got %b expected %b", bus.PAR_ERR, model_par(4'b1011, 1'(p)));
            end
            bus.RDY = 1'b0;
            tick();
            checks++;
            if (bus.VALID !== 1'b1 || bus.Q !== exp_q) begin
                failures++;
                $display("FAIL msb_hold: VALID=%b Q=%b expected 1 %b", bus.VALID, bus.Q, exp_q);
            end
            accept();
            checks++;
            if (bus.VALID !== 1'b0) begin
                failures++;
                $display("FAIL msb_accept: VALID got %b expected 0", bus.VALID);
            end
        end
        // Data on S_IN without a START while idle must not begin a frame.
        bus.ENB = 1'b1; bus.S_IN = 1'b1;
        tick();
        checks++;
        if (bus.BUSY !== 1'b0 || bus.VALID !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_start: BUSY=%b VALID=%b expected 0 0", bus.BUSY, bus.VALID);
        end
    endtask

    task automatic test_lsb_gaps();
        int bb, ve, c0;
        logic [WIDTH-1:0] exp_q;
        bus.ENB = 1'b1; bus.START = 1'b1; bus.DIR = 1'b0;
        c0 = cyc;
        drive_frame(1'b0, 4'b1000, 1'b0, 0, 2, 2, bb, ve);
        exp_q = model_word(1'b0, 4'b1000);
        checks++;
        if (bus.Q !== exp_q || bus.VALID !== 1'b1 || ve != 0 || bb != 0) begin
            failures++;
            $display("FAIL lsb_gaps: Q=%b VALID=%b early=%0d busybad=%0d expected Q=%b", bus.Q, bus.VALID, ve, bb, exp_q);
        end
        checks++;
        if (cyc - c0 != 1 + WIDTH + PBITS + 2) begin
            failures++;
            $display("FAIL lsb_latency: edges got %0d expected %0d", cyc - c0, 1 + WIDTH + PBITS + 2);
        end
        accept();
    endtask

    task automatic test_restart_overrun();
        int bb, ve;
        logic [WIDTH-1:0] exp_q;
        bus.ENB = 1'b1; bus.START = 1'b1; bus.DIR = 1'b0;
        tick();
        bus.START = 1'b0; bus.S_IN = 1'b1;
        tick();
        bus.S_IN = 1'b0;
        tick();
        drive_frame(1'b1, 4'b1100, 1'b0, 0, -1, 0, bb, ve);
        exp_q = model_word(1'b1, 4'b1100);
        checks++;
        if (bus.Q !== exp_q || bus.VALID !== 1'b1 || bus.OVERRUN !== 1'b0) begin
            failures++;
            $display("FAIL restart: Q=%b VALID=%b OVERRUN=%b expected Q=%b 1 0", bus.Q, bus.VALID, bus.OVERRUN, exp_q);
        end
        bus.RDY = 1'b0; bus.ENB = 1'b0; bus.START = 1'b1;
        tick();
        checks++;
        if (bus.OVERRUN !== 1'b0) begin
            failures++;
            $display("FAIL overrun_needs_enb: got %b expected 0", bus.OVERRUN);
        end
        bus.ENB = 1'b1;
        tick();
        bus.START = 1'b0;
        checks++;
        if (bus.OVERRUN !== 1'b1 || bus.Q !== exp_q || bus.VALID !== 1'b1 || bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL overrun: OVERRUN=%b Q=%b VALID=%b BUSY=%b expected 1 %b 1 0", bus.OVERRUN, bus.Q, bus.VALID, bus.BUSY, exp_q);
        end
        accept();
        bus.RDY = 1'b1;
        tick();
        bus.RDY = 1'b0;
        checks++;
        if (bus.OVERRUN !== 1'b1 || bus.VALID !== 1'b0 || bus.Q !== exp_q) begin
            failures++;
            $display("FAIL overrun_sticky: OVERRUN=%b VALID=%b Q=%b expected 1 0 %b", bus.OVERRUN, bus.VALID, bus.Q, exp_q);
        end
        do_reset();
    endtask

    task automatic test_random();
        int bb, ve, w;
        logic dir, pbit;
        logic [WIDTH-1:0] tx, exp_q;
        for (int f = 0; f < 30; f++) begin
            dir  = 1'($urandom);
            pbit = 1'($urandom);
            tx   = WIDTH'($urandom);
            drive_frame(dir, tx, pbit, 3, -1, 0, bb, ve);
            exp_q = model_word(dir, tx);
            checks++;
            if (bus.Q !== exp_q || bus.VALID !== 1'b1 || bus.PAR_ERR !== model_par(tx, pbit) || bb != 0 || ve != 0) begin
                failures++;
                $display("FAIL random_frame %0d: Q=%b VALID=%b PAR_ERR=%b busybad=%0d early=%0d expected Q=%b PAR_ERR=%b",
                         f, bus.Q, bus.VALID, bus.PAR_ERR, bb, ve, exp_q, model_par(tx, pbit));
            end
            w = int'($urandom_range(3, 0));
            for (int k = 0; k < w; k++) begin
                bus.ENB  = 1'($urandom);
                bus.S_IN = 1'($urandom);
                tick();
            end
            checks++;
            if (bus.Q !== exp_q || bus.VALID !== 1'b1) begin
                failures++;
                $display("FAIL random_hold %0d: Q=%b VALID=%b expected %b 1", f, bus.Q, bus.VALID, exp_q);
            end
            accept();
            checks++;
            if (bus.VALID !== 1'b0 || bus.OVERRUN !== 1'b0) begin
                failures++;
                $display("FAIL random_accept %0d: VALID=%b OVERRUN=%b expected 0 0", f, bus.VALID, bus.OVERRUN);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bb, ve, c0;
        logic dir;
        logic [WIDTH-1:0] tx, exp_q;
        c0 = cyc;
        for (int f = 0; f < 3; f++) begin
            dir = 1'($urandom);
            tx  = WIDTH'($urandom);
            drive_frame(dir, tx, 1'b0, 0, -1, 0, bb, ve);
            exp_q = model_word(dir, tx);
            checks++;
            if (bus.Q !== exp_q || bus.VALID !== 1'b1) begin
                failures++;
                $display("FAIL b2b_frame %0d: Q=%b VALID=%b expected %b 1", f, bus.Q, bus.VALID, exp_q);
            end
            accept();
        end
        checks++;
        if (cyc - c0 != 3 * (WIDTH + PBITS + 2)) begin
            failures++;
            $display("FAIL b2b_throughput: cycles got %0d expected %0d", cyc - c0, 3 * (WIDTH + PBITS + 2));
        end
    endtask

    initial begin
        RESET_L   = 1'b0;
        bus.ENB   = 1'b0;
        bus.START = 1'b0;
        bus.DIR   = 1'b0;
        bus.S_IN  = 1'b0;
        bus.RDY   = 1'b0;
        test_reset();
        test_msb_frame();
        test_lsb_gaps();
        test_restart_overrun();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
